// File: rtl/inhibit_driver_sequencer.sv
// Write-side inhibit driver sequencer for bit columns 6, 9, 12 and 14 across eight core modules.
// Latches the addressed side's buffer bits and runs a SETUP / INHIBIT / RECOVER drive cycle.
module inhibit_driver_sequencer #(
    parameter int IH_CYCLES = 4,
    parameter int RC_CYCLES = 2
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       V1,
    input  logic       WRQ,
    input  logic [2:0] MA,
    input  logic       BRA6,
    input  logic       BRA9,
    input  logic       BRA12,
    input  logic       BRA14,
    input  logic       BRB6,
    input  logic       BRB9,
    input  logic       BRB12,
    input  logic       BRB14,
    output logic       IHA6,
    output logic       IHA9,
    output logic       IHA12,
    output logic       IHA14,
    output logic       IHB6,
    output logic       IHB9,
    output logic       IHB12,
    output logic       IHB14,
    output logic [7:0] MWE,
    output logic       BUSY,
    output logic       WDONE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_INHIBIT = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [3:0] IH_LOAD = 4'(IH_CYCLES - 1);
    localparam logic [3:0] RC_LOAD = 4'(RC_CYCLES - 1);

    // Odd module addresses are served by the B-side buffer register.
    function automatic logic [3:0] select_side(input logic odd, input logic [3:0] a_bits,
                                               input logic [3:0] b_bits);
        return odd ? b_bits : a_bits;
    endfunction

    function automatic logic [7:0] decode_module(input logic [2:0] addr);
        return 8'h01 << addr;
    endfunction

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       side_r;
    logic [3:0] data_r;
    logic [3:0] iha_r;
    logic [3:0] ihb_r;
    logic [7:0] mwe_r;
    logic       busy_r;
    logic       wdone_r;
    logic [3:0] bra_s;
    logic [3:0] brb_s;

    // Bit order within the packed vectors is {14, 12, 9, 6}.
    assign bra_s = {BRA14, BRA12, BRA9, BRA6};
    assign brb_s = {BRB14, BRB12, BRB9, BRB6};

    assign {IHA14, IHA12, IHA9, IHA6} = iha_r;
    assign {IHB14, IHB12, IHB9, IHB6} = ihb_r;
    assign MWE   = mwe_r;
    assign BUSY  = busy_r;
    assign WDONE = wdone_r;

    // Sequencer state, drive timing and registered outputs.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            side_r  <= 1'b0;
            data_r  <= 4'd0;
            iha_r   <= 4'd0;
            ihb_r   <= 4'd0;
            mwe_r   <= 8'd0;
            busy_r  <= 1'b0;
            wdone_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    iha_r   <= 4'd0;
                    ihb_r   <= 4'd0;
                    wdone_r <= 1'b0;
                    if (WRQ && V1) begin
                        state_r <= ST_SETUP;
                        side_r  <= MA[0];
                        data_r  <= select_side(MA[0], bra_s, brb_s);
                        mwe_r   <= decode_module(MA);
                        busy_r  <= 1'b1;
                    end else begin
                        mwe_r  <= 8'd0;
                        busy_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (!V1) begin
                        state_r <= ST_RECOVER;
                        cnt_r   <= RC_LOAD;
                        mwe_r   <= 8'd0;
                        iha_r   <= 4'd0;
                        ihb_r   <= 4'd0;
                        wdone_r <= (RC_LOAD == 4'd0);
                    end else begin
                        state_r <= ST_INHIBIT;
                        cnt_r   <= IH_LOAD;
                        // Inhibit current writes a 0, so drive is the inverse of the stored bit.
                        if (side_r) begin
                            ihb_r <= ~data_r;
                        end else begin
                            iha_r <= ~data_r;
                        end
                    end
                end
                ST_INHIBIT: begin
                    if (!V1 || cnt_r == 4'd0) begin
                        state_r <= ST_RECOVER;
                        cnt_r   <= RC_LOAD;
                        mwe_r   <= 8'd0;
                        iha_r   <= 4'd0;
                        ihb_r   <= 4'd0;
                        wdone_r <= (RC_LOAD == 4'd0);
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        wdone_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        wdone_r <= (cnt_r == 4'd1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    iha_r   <= 4'd0;
                    ihb_r   <= 4'd0;
                    mwe_r   <= 8'd0;
                    busy_r  <= 1'b0;
                    wdone_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inhibit_driver_sequencer.sv
// Bench for inhibit_driver_sequencer: default instance plus a minimum-timing instance (IH=1, RC=1),
// both checked every cycle against a write-timeline model, plus table and corner-case sequences.
module tb_inhibit_driver_sequencer;

    logic       clk_s = 1'b0;
    logic       rst_s = 1'b1;
    logic       v1_s = 1'b0;
    logic       wrq_s = 1'b0;
    logic [2:0] ma_s = 3'd0;
    logic [3:0] bra_s = 4'd0;
    logic [3:0] brb_s = 4'd0;

    logic [3:0]  iha_s [2];
    logic [3:0]  ihb_s [2];
    logic [7:0]  mwe_s [2];
    logic        busy_s [2];
    logic        wdone_s [2];
    logic [17:0] act_s [2];

    int checks = 0;
    int failures = 0;

    // Model: position within the current write (0 = idle, 1 = setup cycle, ...).
    int         pos_m [2];
    int         rec_start_m [2];
    int         ih_m [2];
    int         rc_m [2];
    logic [2:0] ma_m [2];
    logic [3:0] data_m [2];

    typedef struct {
        logic        wrq;
        logic [2:0]  ma;
        logic [3:0]  bra;
        logic [17:0] exp;
    } vec_t;
    vec_t tbl [8];

    always #5 clk_s = ~clk_s;

    inhibit_driver_sequencer #(.IH_CYCLES(4), .RC_CYCLES(2)) dut0 (
        .SIM_CLK(clk_s), .SIM_RST(rst_s), .V1(v1_s), .WRQ(wrq_s), .MA(ma_s),
        .BRA6(bra_s[0]), .BRA9(bra_s[1]), .BRA12(bra_s[2]), .BRA14(bra_s[3]),
        .BRB6(brb_s[0]), .BRB9(brb_s[1]), .BRB12(brb_s[2]), .BRB14(brb_s[3]),
        .IHA6(iha_s[0][0]), .IHA9(iha_s[0][1]), .IHA12(iha_s[0][2]), .IHA14(iha_s[0][3]),
        .IHB6(ihb_s[0][0]), .IHB9(ihb_s[0][1]), .IHB12(ihb_s[0][2]), .IHB14(ihb_s[0][3]),
        .MWE(mwe_s[0]), .BUSY(busy_s[0]), .WDONE(wdone_s[0])
    );

    inhibit_driver_sequencer #(.IH_CYCLES(1), .RC_CYCLES(1)) dut1 (
        .SIM_CLK(clk_s), .SIM_RST(rst_s), .V1(v1_s), .WRQ(wrq_s), .MA(ma_s),
        .BRA6(bra_s[0]), .BRA9(bra_s[1]), .BRA12(bra_s[2]), .BRA14(bra_s[3]),
        .BRB6(brb_s[0]), .BRB9(brb_s[1]), .BRB12(brb_s[2]), .BRB14(brb_s[3]),
        .IHA6(iha_s[1][0]), .IHA9(iha_s[1][1]), .IHA12(iha_s[1][2]), .IHA14(iha_s[1][3]),
        .IHB6(ihb_s[1][0]), .IHB9(ihb_s[1][1]), .IHB12(ihb_s[1][2]), .IHB14(ihb_s[1][3]),
        .MWE(mwe_s[1]), .BUSY(busy_s[1]), .WDONE(wdone_s[1])
    );

    assign act_s[0] = {busy_s[0], wdone_s[0], mwe_s[0], iha_s[0], ihb_s[0]};
    assign act_s[1] = {busy_s[1], wdone_s[1], mwe_s[1], iha_s[1], ihb_s[1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos_m[k] = 0;
            rec_start_m[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic wrq, input logic v1, input logic [2:0] ma,
                              input logic [3:0] bra, input logic [3:0] brb);
        if (pos_m[k] == 0) begin
            if (wrq && v1) begin
                pos_m[k] = 1;
                rec_start_m[k] = 2 + ih_m[k];
                ma_m[k] = ma;
                data_m[k] = ma[0] ? brb : bra;
            end
        end else begin
            if (!v1 && pos_m[k] < rec_start_m[k]) rec_start_m[k] = pos_m[k] + 1;
            if (pos_m[k] == rec_start_m[k] + rc_m[k] - 1) pos_m[k] = 0;
            else pos_m[k] = pos_m[k] + 1;
        end
    endtask

    function automatic logic [17:0] model_out(input int k);
        logic       busy, wd;
        logic [7:0] mwe;
        logic [3:0] iha, ihb;
        busy = (pos_m[k] != 0);
        wd   = busy && (pos_m[k] == rec_start_m[k] + rc_m[k] - 1);
        mwe  = (busy && pos_m[k] < rec_start_m[k]) ? (8'h01 << ma_m[k]) : 8'h00;
        iha  = 4'd0;
        ihb  = 4'd0;
        if (pos_m[k] >= 2 && pos_m[k] < rec_start_m[k]) begin
            if (ma_m[k][0]) ihb = ~data_m[k];
            else iha = ~data_m[k];
        end
        return {busy, wd, mwe, iha, ihb};
    endfunction

    task automatic step(input logic wrq, input logic v1, input logic [2:0] ma,
                        input logic [3:0] bra, input logic [3:0] brb);
        wrq_s = wrq; v1_s = v1; ma_s = ma; bra_s = bra; brb_s = brb;
        @(posedge clk_s);
        for (int k = 0; k < 2; k++) model_step(k, wrq, v1, ma, bra, brb);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_dut%0d", k), 32'(act_s[k]), 32'(model_out(k)));
            chk($sformatf("onehot_dut%0d", k), 32'($countones(mwe_s[k]) <= 1), 32'd1);
            chk($sformatf("ihexcl_dut%0d", k), 32'(!((|iha_s[k]) && (|ihb_s[k]))), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'd0, 4'd0, 4'd0);
    endtask

    initial begin
        int starts [$];
        int wd_cnt, busy_cnt, wd1_cnt;
        logic prev_busy;

        ih_m[0] = 4; rc_m[0] = 2;
        ih_m[1] = 1; rc_m[1] = 1;
        model_reset();

        // Even write, MA=2, BRA {14,12,9,6} = 0101; buffer bits change after latching.
        tbl[0] = '{1'b1, 3'd2, 4'b0101, {1'b1, 1'b0, 8'h04, 4'h0, 4'h0}};
        tbl[1] = '{1'b0, 3'd2, 4'b1111, {1'b1, 1'b0, 8'h04, 4'b1010, 4'h0}};
        tbl[2] = '{1'b0, 3'd5, 4'b0000, {1'b1, 1'b0, 8'h04, 4'b1010, 4'h0}};
        tbl[3] = '{1'b0, 3'd2, 4'b0110, {1'b1, 1'b0, 8'h04, 4'b1010, 4'h0}};
        tbl[4] = '{1'b0, 3'd2, 4'b0101, {1'b1, 1'b0, 8'h04, 4'b1010, 4'h0}};
        tbl[5] = '{1'b0, 3'd2, 4'b0101, {1'b1, 1'b0, 8'h00, 4'h0, 4'h0}};
        tbl[6] = '{1'b0, 3'd2, 4'b0101, {1'b1, 1'b1, 8'h00, 4'h0, 4'h0}};
        tbl[7] = '{1'b0, 3'd2, 4'b0101, {1'b0, 1'b0, 8'h00, 4'h0, 4'h0}};

        repeat (2) @(posedge clk_s);
        #1;
        chk("reset_dut0", 32'(act_s[0]), 32'd0);
        chk("reset_dut1", 32'(act_s[1]), 32'd0);
        rst_s = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wrq, 1'b1, tbl[i].ma, tbl[i].bra, 4'd0);
            chk($sformatf("even_row%0d", i), 32'(act_s[0]), 32'(tbl[i].exp));
        end
        idle(3);

        // Odd write: BRB latched as 0000, then forced to 1111 during the drive.
        step(1'b1, 1'b1, 3'd7, 4'hF, 4'h0);
        chk("odd_setup_mwe", 32'(mwe_s[0]), 32'h80);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 3'd7, 4'hF, 4'hF);
            chk("odd_ihb", 32'(ihb_s[0]), 32'hF);
            chk("odd_iha", 32'(iha_s[0]), 32'h0);
            chk("odd_mwe", 32'(mwe_s[0]), 32'h80);
        end
        idle(4);

        // V1 dropped while in the second INHIBIT cycle.
        step(1'b1, 1'b1, 3'd3, 4'h0, 4'h5);
        step(1'b0, 1'b1, 3'd3, 4'h0, 4'h5);
        step(1'b0, 1'b1, 3'd3, 4'h0, 4'h5);
        chk("v1_inh2_ihb", 32'(ihb_s[0]), 32'hA);
        step(1'b0, 1'b0, 3'd3, 4'h0, 4'h5);
        chk("v1_abort_drive", 32'({mwe_s[0], iha_s[0], ihb_s[0]}), 32'd0);
        chk("v1_abort_busy", 32'({busy_s[0], wdone_s[0]}), 32'b10);
        step(1'b1, 1'b0, 3'd3, 4'h0, 4'h5);
        chk("v1_rec_wdone", 32'({busy_s[0], wdone_s[0]}), 32'b11);
        step(1'b1, 1'b0, 3'd3, 4'h0, 4'h5);
        chk("v1_idle", 32'(busy_s[0]), 32'd0);
        step(1'b1, 1'b0, 3'd3, 4'h0, 4'h5);
        chk("v1_low_no_accept", 32'(busy_s[0]), 32'd0);
        idle(3);

        // WRQ held high for 20 cycles.
        prev_busy = busy_s[0];
        wd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 3'd4, 4'h3, 4'h0);
            if (busy_s[0] && !prev_busy) starts.push_back(i);
            if (i < 16 && wdone_s[0]) wd_cnt++;
            prev_busy = busy_s[0];
        end
        chk("b2b_nstarts", 32'(starts.size()), 32'd3);
        if (starts.size() >= 2) begin
            chk("b2b_start0", 32'(starts[0]), 32'd0);
            chk("b2b_start1", 32'(starts[1]), 32'd8);
        end
        chk("b2b_wdone", 32'(wd_cnt), 32'd2);
        idle(8);

        // Minimum-timing instance: a single write is busy for 3 cycles.
        busy_cnt = 0;
        wd1_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 1'b1, 3'd1, 4'h0, 4'h6);
            if (busy_s[1]) busy_cnt++;
            if (wdone_s[1]) wd1_cnt++;
        end
        chk("sweep_busy", 32'(busy_cnt), 32'd3);
        chk("sweep_wdone", 32'(wd1_cnt), 32'd1);
        idle(3);

        // Asynchronous reset mid-INHIBIT.
        step(1'b1, 1'b1, 3'd2, 4'h0, 4'h0);
        step(1'b0, 1'b1, 3'd2, 4'h0, 4'h0);
        step(1'b0, 1'b1, 3'd2, 4'h0, 4'h0);
        chk("pre_rst_iha", 32'(iha_s[0]), 32'hF);
        #3;
        rst_s = 1'b1;
        #1;
        chk("rst_async_dut0", 32'(act_s[0]), 32'd0);
        chk("rst_async_dut1", 32'(act_s[1]), 32'd0);
        model_reset();
        #1;
        rst_s = 1'b0;
        step(1'b0, 1'b1, 3'd2, 4'h0, 4'h0);
        chk("post_rst_busy", 32'(busy_s[0]), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, $urandom_range(9) != 0, 3'($urandom_range(7)),
                 4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inhibit_driver_sequencer.md
Name: inhibit_driver_sequencer

Overview:
- Write-side counterpart of the buffer-register load path for bit columns 6, 9, 12 and 14.
- Reads use this path: sense amplifiers load BRA from even modules and BRB from odd modules.
- On a write, this block latches the buffer-register bits for the addressed module and drives the core-memory inhibit lines for those columns. It also asserts that module's write enable.
- Drive is timed by a fixed setup/inhibit/recovery sequence. One instance serves all eight memory modules.

Parameters:
- IH_CYCLES, 4, clock cycles the inhibit/write-enable drive is held (legal range 1-15).
- RC_CYCLES, 2, recovery cycles with all drives off before the next write is accepted (legal range 1-15).

Ports:
- SIM_CLK  input  1  simulation clock; all state changes on the rising edge.
- SIM_RST  input  1  asynchronous, active-high reset.
- V1  input  1  supply-valid gate. Low disables all drive.
- WRQ  input  1  write request. Sampled in IDLE only.
- MA  input  3  module address, 0-7. Even addresses are the A side, odd addresses are the B side.
- BRA6, BRA9, BRA12, BRA14  input  1 each  A-side buffer-register bits. BRA14 is parity.
- BRB6, BRB9, BRB12, BRB14  input  1 each  B-side buffer-register bits. BRB14 is parity.
- IHA6, IHA9, IHA12, IHA14  output  1 each  A-side inhibit drivers. Active high means "write 0".
- IHB6, IHB9, IHB12, IHB14  output  1 each  B-side inhibit drivers.
- MWE  output  8  one-hot module write enable. Bit n selects module n.
- BUSY  output  1  high while a write sequence is in progress.
- WDONE  output  1  one-cycle pulse at the end of recovery.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset acts asynchronously, including mid-sequence: drives drop immediately and nothing is latched afterwards.
- All outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, SETUP, INHIBIT, RECOVER. A 4-bit down-counter CNT times INHIBIT and RECOVER.
- IDLE to SETUP: on an edge with WRQ=1 and V1=1, the block makes the transition and on the same edge:
  - latches MA;
  - latches the four bits of the selected side: BRA* if MA[0]=0, BRB* if MA[0]=1.
- Bits are latched once per write. Later buffer-register changes are ignored until the next write.
- SETUP: lasts exactly 1 cycle.
  - BUSY=1, MWE[MA]=1, all IH outputs 0 (address settles before inhibit).
  - Next state INHIBIT, with CNT loaded to IH_CYCLES-1.
- INHIBIT: lasts IH_CYCLES cycles.
  - MWE[MA]=1.
  - On the selected side, each IH bit is the inverse of its latched BR bit.
  - The unselected side's IH outputs stay 0.
  - When CNT=0, next state is RECOVER with CNT loaded to RC_CYCLES-1.
- RECOVER: lasts RC_CYCLES cycles.
  - MWE=0 and all IH outputs 0; BUSY stays 1.
  - On the last cycle (CNT=0), WDONE=1 and the next state is IDLE.
- IDLE: BUSY=0, WDONE=0, MWE=0, all IH outputs 0.
- Latency and spacing:
  - BUSY rises 1 edge after WRQ is sampled.
  - Total busy time is 1+IH_CYCLES+RC_CYCLES cycles (7 at defaults).
  - A WRQ held high starts back-to-back writes, with one IDLE cycle between sequences.
- WRQ in any non-IDLE state is ignored. It is neither queued nor an error.
- V1 low in SETUP or INHIBIT:
  - Next edge: MWE and IH outputs go to 0 and the state is RECOVER, with CNT loaded to RC_CYCLES-1.
  - The aborted write still completes its recovery and still pulses WDONE.
- V1 low in RECOVER: counting continues normally.
- V1 low in IDLE: WRQ is not accepted.
- At most one MWE bit is high at any time. IHA* and IHB* are never non-zero in the same cycle.

Test Plan:
- Reset mid-INHIBIT: assert SIM_RST between clock edges -> all outputs 0 before the next edge. After release, state IDLE and BUSY=0.
- Even write:
  - Stimulus: MA=2; BRA6=1, BRA9=0, BRA12=1, BRA14=0; WRQ pulse.
  - Setup: BUSY high on the next edge; MWE=8'h04 for 5 cycles; IH outputs 0 during the SETUP cycle.
  - Inhibit: for the 4 INHIBIT cycles IHA9=IHA14=1, IHA6=IHA12=0, IHB*=0.
  - Recovery: 2 idle-drive cycles, WDONE on the second; BUSY low after 7 cycles.
- Odd write with data change:
  - Stimulus: MA=7; BRB*=0000 latched, then BRB* changed to 1111 during INHIBIT.
  - Response: MWE=8'h80; IHB6..IHB14 all 1 throughout INHIBIT; IHA* always 0.
- WRQ held high for 20 cycles:
  - Writes start at cycles 1 and 9 (7 busy + 1 idle).
  - WRQ pulses during BUSY produce no extra sequence; exactly 2 WDONE pulses by cycle 16.
- V1 dropped in the 2nd INHIBIT cycle:
  - Next edge: MWE=0, IH=0.
  - RECOVER lasts 2 cycles with WDONE pulsed; WRQ with V1=0 afterwards is not accepted.
- Parameter sweep IH_CYCLES=1, RC_CYCLES=1: busy time is 3 cycles, and one-hot MWE and mutually exclusive IH sides hold (checked by an assertion every cycle).
